lsu_mem_port: RTL

Parametrised multicycle load/store unit sitting between the processor control FSM and data memory. It generalises the fixed 16-bit, single-cycle memory access path to configurable data and address widths, and adds a memory ready handshake, byte-lane stores, sign- or zero-extended byte loads, misalignment detection and an optional access timeout. The control FSM issues one request, waits for `done`, and takes `rdata` into the memory data register path.

---
 rtl/lsu_mem_port.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// Multicycle load/store unit between the control FSM and a ready-handshaked data memory.
// Optional access timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_port #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic                size,
  input  logic                sext,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = (DATA_W == 32) ? 2 : 1;

  if ((DATA_W != 16 && DATA_W != 32) || TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_cfg
    $error("lsu_mem_port: DATA_W must be 16 or 32 and TIMEOUT must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  logic            lat_we;
  logic            lat_size;
  logic            lat_sext;
  logic [LB-1:0]   lat_lane;

  logic [LB-1:0]   lane_c;
  logic            misaligned_c;
  logic [7:0]      byte_c;
  logic [DATA_W-1:0] load_c;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  logic [7:0] tcount;
`endif

  assign lane_c       = addr[LB-1:0];
  assign misaligned_c = size && (lane_c != '0);

  // Load result: full word, or the addressed lane extended to DATA_W.
  always_comb begin
    byte_c = '0;
    for (int i = 0; i < NB; i++) begin
      if (lat_lane == LB'(i)) byte_c = mem_rdata[8*i +: 8];
    end
    if (lat_size) load_c = mem_rdata;
    else          load_c = {{(DATA_W-8){lat_sext & byte_c[7]}}, byte_c};
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      lat_we    <= 1'b0;
      lat_size  <= 1'b0;
      lat_sext  <= 1'b0;
      lat_lane  <= '0;
`ifdef LSU_TIMEOUT_EN
      tcount    <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ACCESS: begin
          if (mem_ready) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!lat_we) rdata <= load_c;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tcount + 8'd1 == TO_LIM) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            tcount <= tcount + 8'd1;
          end
`endif
        end
        default: begin
          // IDLE and DONE both accept a new request, allowing back-to-back accesses.
          state <= IDLE;
          if (req) begin
            if (misaligned_c) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              busy      <= 1'b1;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= addr >> LB;
              mem_be    <= size ? '1 : (NB'(1) << lane_c);
              mem_wdata <= size ? wdata : {NB{wdata[7:0]}};
              lat_we    <= we;
              lat_size  <= size;
              lat_sext  <= sext;
              lat_lane  <= lane_c;
`ifdef LSU_TIMEOUT_EN
              tcount    <= '0;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule
